if_stage: RTL

- Instruction-fetch stage of the LoongArch 5-stage pipeline.
- Produces the `{inst, pc}` bus and valid to the decode stage, and consumes decode's `{br_taken, br_target}` redirect.
- Fetches through an SRAM-like instruction interface (req/addr_ok/data_ok) with a pre-IF request stage, so instruction latency is variable.
- Holds returned instructions while decode back-pressures, and discards wrong-path responses after a redirect.

---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_stage.sv | 126 ++++++++++++
 2 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and bus layouts for the fetch stage and its decode-side consumer.
// Decode unpacks fs_to_ds_bus and packs br_collect using the same widths.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC        = 32'h1c000000;
  localparam int          MAX_OUTSTANDING = 2;
  localparam int          FS_TO_DS_BUS_W  = 64;
  localparam int          BR_COLLECT_W    = 33;

  localparam logic [1:0]  SIZE_BYTE = 2'd0;
  localparam logic [1:0]  SIZE_HALF = 2'd1;
  localparam logic [1:0]  SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_bus_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_collect_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: pre-IF request over an SRAM-like interface, one IF entry,
// a holding buffer for decode back-pressure and a discard counter for wrong-path data.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = if_stage_pkg::RESET_PC,
  parameter int          MAX_OUTSTANDING = if_stage_pkg::MAX_OUTSTANDING
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ds_allowin,
  input  logic [BR_COLLECT_W-1:0]   br_collect,
  output logic                      fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [1:0]                inst_sram_size,
  output logic [3:0]                inst_sram_wstrb,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  br_collect_t      br;
  fs_to_ds_bus_t    bus;
  logic [31:0]      pf_pc;
  logic [31:0]      fs_pc;
  logic [31:0]      inst_buf;
  logic [31:0]      br_buf_target;
  logic             fs_valid;
  logic             inst_buf_valid;
  logic             br_buf_valid;
  logic [CNT_W-1:0] discard_cnt;

  logic [31:0]      nextpc;
  logic [31:0]      fs_inst;
  logic             br_kill;
  logic             data_hit;
  logic             fs_ready_go;
  logic             fs_allowin;
  logic             pf_hs;
  logic             ds_hs;
  logic             disc_inc;
  logic             disc_dec;

  assign br       = br_collect;
  assign br_kill  = br.taken;
  assign nextpc   = br.taken     ? br.target     :
                    br_buf_valid ? br_buf_target : pf_pc;

  // data_ok only belongs to the current entry once every stale response is drained
  assign data_hit    = inst_sram_data_ok && (discard_cnt == '0);
  assign fs_ready_go = fs_valid && (inst_buf_valid || data_hit);
  assign fs_allowin  = !fs_valid || (fs_ready_go && ds_allowin) || br_kill;
  assign pf_hs       = inst_sram_req && inst_sram_addr_ok;
  assign ds_hs       = fs_to_ds_valid && ds_allowin;

  assign disc_inc = br_kill && fs_valid && !inst_buf_valid && !data_hit;
  assign disc_dec = inst_sram_data_ok && (discard_cnt != '0);

  assign fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata;
  assign bus     = '{inst: fs_inst, pc: fs_pc};

  assign fs_to_ds_valid = !reset && fs_valid && fs_ready_go && !br_kill;
  assign fs_to_ds_bus   = reset ? '0 : bus;

  assign inst_sram_req   = !reset && fs_allowin;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SIZE_WORD;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_pc          <= RESET_PC;
      fs_pc          <= 32'd0;
      inst_buf       <= 32'd0;
      br_buf_target  <= 32'd0;
      fs_valid       <= 1'b0;
      inst_buf_valid <= 1'b0;
      br_buf_valid   <= 1'b0;
      discard_cnt    <= '0;
    end else begin
      if (pf_hs) begin
        // an accepted request in a kill cycle already fetched the redirect target
        fs_valid     <= 1'b1;
        fs_pc        <= nextpc;
        pf_pc        <= nextpc + 32'd4;
        br_buf_valid <= 1'b0;
      end else begin
        if (br.taken) begin
          br_buf_valid  <= 1'b1;
          br_buf_target <= br.target;
        end
        if (br_kill || ds_hs) begin
          fs_valid <= 1'b0;
        end
      end

      if (pf_hs || br_kill || ds_hs) begin
        inst_buf_valid <= 1'b0;
      end else if (data_hit && fs_valid && !inst_buf_valid && !ds_allowin) begin
        inst_buf_valid <= 1'b1;
        inst_buf       <= inst_sram_rdata;
      end

      if (disc_inc && !disc_dec && (discard_cnt != CNT_W'(MAX_OUTSTANDING))) begin
        discard_cnt <= discard_cnt + CNT_W'(1);
      end else if (!disc_inc && disc_dec) begin
        discard_cnt <= discard_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(disc_inc && !disc_dec && (discard_cnt == CNT_W'(MAX_OUTSTANDING))));
    end
  end

endmodule
